ber_checker: RTL and testbench

- Bit-error-rate checker at the receiver tail, downstream of the 2-bit phase counter (`control`).
- Consumes one decided bit per symbol, qualified by a strobe. The strobe is the counter's `o_count_max` pulse, one clk in four.
- Finds the latency between the local reference bit stream (PRBS9) and the received stream, locks, then accumulates total-bit and error counts for BER readout.

---
 rtl/ber_checker.sv | 142 ++++++++++++++
 tb/tb_ber_checker.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ber_checker.sv
// Bit-error-rate checker: searches the latency between a local PRBS reference
// and the received bit stream, locks, then accumulates bit and error counts.
//
// state    | meaning
// SEARCH   | one WIN-strobe window per candidate latency, lock on a clean window
// LOCKED   | counting bits/errors, drop lock when a window reaches LOSS_TH errors
module ber_checker #(
  parameter int DEPTH   = 512,
  parameter int LAT_W   = 9,
  parameter int WIN     = 511,
  parameter int LOSS_TH = 128,
  parameter int CNT_W   = 64
) (
  input  logic             clk,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic             i_valid,
  input  logic             i_ref_bit,
  input  logic             i_rx_bit,
  output logic             o_lock,
  output logic [LAT_W-1:0] o_latency,
  output logic [CNT_W-1:0] o_bit_count,
  output logic [CNT_W-1:0] o_err_count
);

  localparam int WC_W = $clog2(WIN + 1);

  typedef enum logic {
    ST_SEARCH,
    ST_LOCKED
  } state_t;

  state_t            state_q, state_d;
  logic              lock_q, lock_d;
  logic [DEPTH-2:0]  dly_q, dly_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [WC_W-1:0]   win_cnt_q, win_cnt_d;
  logic [WC_W-1:0]   win_err_q, win_err_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;

  logic              strobe;
  logic [DEPTH-1:0]  taps;
  logic              err_bit;
  logic              win_end;
  logic [WC_W:0]     win_err_sum;
  logic [LAT_W-1:0]  lat_next;

  assign strobe      = i_valid & i_enable;
  // Tap 0 is the live reference bit, so latency 0 needs no delay.
  assign taps        = {dly_q, i_ref_bit};
  assign err_bit     = i_rx_bit ^ taps[lat_q];
  assign win_end     = (win_cnt_q == WC_W'(WIN - 1));
  assign win_err_sum = {1'b0, win_err_q} + (WC_W + 1)'(err_bit);
  assign lat_next    = (lat_q == LAT_W'(DEPTH - 1)) ? '0 : lat_q + LAT_W'(1);

  always_comb begin
    state_d   = state_q;
    lock_d    = lock_q;
    dly_d     = dly_q;
    lat_d     = lat_q;
    win_cnt_d = win_cnt_q;
    win_err_d = win_err_q;
    bit_cnt_d = bit_cnt_q;
    err_cnt_d = err_cnt_q;

    if (strobe) begin
      dly_d     = taps[DEPTH-2:0];
      win_cnt_d = win_cnt_q + WC_W'(1);
      win_err_d = win_err_q + WC_W'(err_bit);

      case (state_q)
        ST_SEARCH: begin
          if (win_end) begin
            win_cnt_d = '0;
            win_err_d = '0;
            if (win_err_sum == '0) begin
              state_d   = ST_LOCKED;
              lock_d    = 1'b1;
              bit_cnt_d = '0;
              err_cnt_d = '0;
            end else begin
              lat_d = lat_next;
            end
          end
        end

        ST_LOCKED: begin
          // Counters saturate rather than wrap so a long run never reads as a short one.
          if (bit_cnt_q != '1) begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
          if (err_bit && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
          end
          if (win_end) begin
            win_cnt_d = '0;
            win_err_d = '0;
            if (win_err_sum >= (WC_W + 1)'(LOSS_TH)) begin
              state_d = ST_SEARCH;
              lock_d  = 1'b0;
              lat_d   = lat_next;
            end
          end
        end

        default: begin
          state_d = ST_SEARCH;
          lock_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_q   <= ST_SEARCH;
      lock_q    <= 1'b0;
      dly_q     <= '0;
      lat_q     <= '0;
      win_cnt_q <= '0;
      win_err_q <= '0;
      bit_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      lock_q    <= lock_d;
      dly_q     <= dly_d;
      lat_q     <= lat_d;
      win_cnt_q <= win_cnt_d;
      win_err_q <= win_err_d;
      bit_cnt_q <= bit_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign o_lock      = lock_q;
  assign o_latency   = lat_q;
  assign o_bit_count = bit_cnt_q;
  assign o_err_count = err_cnt_q;

endmodule

// File: tb/tb_ber_checker.sv
// Bench for ber_checker: full-size instance for search/lock/loss, and a small
// instance (DEPTH 8, WIN 7, 4-bit counters) for latency wrap and saturation.
module tb_ber_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic i_reset, i_enable;
  logic v_big, ref_big, rx_big;
  logic v_s, ref_s, rx_s;

  logic        lock_b;
  logic [8:0]  lat_b;
  logic [63:0] bc_b, ec_b;
  logic        lock_s;
  logic [2:0]  lat_s;
  logic [3:0]  bc_s, ec_s;

  ber_checker dut (
    .clk        (clk),
    .i_reset    (i_reset),
    .i_enable   (i_enable),
    .i_valid    (v_big),
    .i_ref_bit  (ref_big),
    .i_rx_bit   (rx_big),
    .o_lock     (lock_b),
    .o_latency  (lat_b),
    .o_bit_count(bc_b),
    .o_err_count(ec_b)
  );

  ber_checker #(
    .DEPTH  (8),
    .LAT_W  (3),
    .WIN    (7),
    .LOSS_TH(4),
    .CNT_W  (4)
  ) dut_s (
    .clk        (clk),
    .i_reset    (i_reset),
    .i_enable   (i_enable),
    .i_valid    (v_s),
    .i_ref_bit  (ref_s),
    .i_rx_bit   (rx_s),
    .o_lock     (lock_s),
    .o_latency  (lat_s),
    .o_bit_count(bc_s),
    .o_err_count(ec_s)
  );

  typedef struct {
    string       tag;
    bit          sel;
    logic        lock;
    logic [8:0]  lat;
    logic [63:0] bc;
    logic [63:0] ec;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [8:0] prbs;
  bit         hist[$];
  int         t_big;
  int         tb_lat;
  int         t_s;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // Monitor: outputs are registered, so everything expected after a strobe
  // edge is compared on the following falling edge.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      if (cur.sel == 1'b0) begin
        chk({cur.tag, ".lock"}, {63'd0, lock_b}, {63'd0, cur.lock});
        chk({cur.tag, ".latency"}, {55'd0, lat_b}, {55'd0, cur.lat});
        chk({cur.tag, ".bit_count"}, bc_b, cur.bc);
        chk({cur.tag, ".err_count"}, ec_b, cur.ec);
      end else begin
        chk({cur.tag, ".lock"}, {63'd0, lock_s}, {63'd0, cur.lock});
        chk({cur.tag, ".latency"}, {61'd0, lat_s}, {55'd0, cur.lat});
        chk({cur.tag, ".bit_count"}, {60'd0, bc_s}, cur.bc);
        chk({cur.tag, ".err_count"}, {60'd0, ec_s}, cur.ec);
      end
    end
  end

  task automatic expect_out(input string tag, input bit sel, input logic lk, input int lat,
                            input longint unsigned bc, input longint unsigned ec);
    exp_t e;
    e.tag  = tag;
    e.sel  = sel;
    e.lock = lk;
    e.lat  = 9'(lat);
    e.bc   = bc;
    e.ec   = ec;
    exp_q.push_back(e);
  endtask

  // One strobe on the big instance; rx is the reference delayed tb_lat strobes,
  // with zeros before the first reference bit (matching a cleared delay line).
  task automatic big_sym(input bit inv, input int gap);
    bit r, d;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    r    = prbs[8] ^ prbs[4];
    prbs = {prbs[7:0], r};
    hist.push_back(r);
    d = (t_big >= tb_lat) ? hist[t_big - tb_lat] : 1'b0;
    t_big++;
    v_big   = 1'b1;
    ref_big = r;
    rx_big  = d ^ inv;
    @(posedge clk);
    #1 v_big = 1'b0;
  endtask

  task automatic big_run(input int n, input bit inv, input int gap);
    repeat (n) big_sym(inv, gap);
  endtask

  // Small instance: reference has a single 1 every 8 strobes, rx is it delayed 7.
  task automatic small_sym(input bit inv);
    @(negedge clk);
    v_s   = 1'b1;
    ref_s = (t_s % 8 == 0);
    rx_s  = ((t_s >= 7) && ((t_s - 7) % 8 == 0)) ^ inv;
    t_s++;
    @(posedge clk);
    #1 v_s = 1'b0;
  endtask

  task automatic restart_ref(input int lat);
    prbs = 9'h1FF;
    hist.delete();
    t_big  = 0;
    tb_lat = lat;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    i_reset  = 1'b0;
    i_enable = 1'b1;
    v_big    = 1'b0;
    ref_big  = 1'b0;
    rx_big   = 1'b0;
    v_s      = 1'b0;
    ref_s    = 1'b0;
    rx_s     = 1'b0;
    t_s      = 0;
    restart_ref(0);

    // Reset with random activity on the data inputs.
    @(negedge clk);
    i_reset = 1'b1;
    repeat (3) begin
      v_big   = 1'($urandom);
      ref_big = 1'($urandom);
      rx_big  = 1'($urandom);
      @(posedge clk);
      #1;
    end
    expect_out("reset", 1'b0, 1'b0, 0, 0, 0);
    expect_out("reset_s", 1'b1, 1'b0, 0, 0, 0);
    @(negedge clk);
    i_reset  = 1'b0;
    i_enable = 1'b0;

    // Disabled: toggling strobes must not move anything.
    repeat (20) begin
      @(negedge clk);
      v_big   = ~v_big;
      ref_big = 1'($urandom);
      rx_big  = 1'($urandom);
    end
    @(posedge clk);
    #1;
    expect_out("disabled", 1'b0, 1'b0, 0, 0, 0);
    @(negedge clk);
    v_big    = 1'b0;
    i_enable = 1'b1;

    // Zero latency with 1-in-4 strobes.
    restart_ref(0);
    big_run(510, 1'b0, 3);
    expect_out("zl_510", 1'b0, 1'b0, 0, 0, 0);
    big_run(1, 1'b0, 3);
    expect_out("zl_lock", 1'b0, 1'b1, 0, 0, 0);
    big_run(100, 1'b0, 0);
    expect_out("zl_100", 1'b0, 1'b1, 0, 100, 0);

    // Reset mid-window while locked.
    @(negedge clk);
    i_reset = 1'b1;
    @(posedge clk);
    #1;
    expect_out("reset_locked", 1'b0, 1'b0, 0, 0, 0);
    @(negedge clk);
    i_reset = 1'b0;

    // Latency 37, back-to-back strobes.
    restart_ref(37);
    big_run(37 * 511, 1'b0, 0);
    expect_out("l37_search", 1'b0, 1'b0, 37, 0, 0);
    big_run(511, 1'b0, 0);
    expect_out("l37_lock", 1'b0, 1'b1, 37, 0, 0);
    big_run(1000, 1'b0, 0);
    expect_out("l37_1000", 1'b0, 1'b1, 37, 1000, 0);
    big_run(1, 1'b1, 0);
    expect_out("single_err", 1'b0, 1'b1, 37, 1001, 1);
    big_run(21, 1'b0, 0);
    expect_out("win_close_1err", 1'b0, 1'b1, 37, 1022, 1);
    big_run(128, 1'b1, 0);
    big_run(382, 1'b0, 0);
    expect_out("before_loss", 1'b0, 1'b1, 37, 1532, 129);
    big_run(1, 1'b0, 0);
    expect_out("loss", 1'b0, 1'b0, 38, 1533, 129);
    big_run(10, 1'b0, 0);
    expect_out("frozen", 1'b0, 1'b0, 38, 1533, 129);

    // Small instance: lock at latency DEPTH-1, saturate, lose lock and wrap.
    repeat (49) small_sym(1'b0);
    expect_out("s_search", 1'b1, 1'b0, 7, 0, 0);
    repeat (7) small_sym(1'b0);
    expect_out("s_lock", 1'b1, 1'b1, 7, 0, 0);
    repeat (14) small_sym(1'b0);
    expect_out("s_14", 1'b1, 1'b1, 7, 14, 0);
    repeat (3) small_sym(1'b0);
    expect_out("s_sat", 1'b1, 1'b1, 7, 15, 0);
    repeat (4) small_sym(1'b1);
    expect_out("s_wrap", 1'b1, 1'b0, 0, 15, 4);

    repeat (3) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
